// File: rtl/multi_alarm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multi_alarm
//  Purpose  : Multi-slot BCD alarm engine. Holds N_ALARMS programmable alarm
//             times, compares them against the running clock on every
//             tick_1hz, picks the lowest-index triggered slot and drives a
//             gated square-wave piezo tone until ack, disarm or timeout.
//  Options  : MULTI_ALARM_SNOOZE_EN - when defined, a snooze pulse while
//             ringing stops the tone and re-triggers the slot SNOOZE_SECS
//             seconds later. When undefined the snooze input is ignored.
//  Ports    : clk_1Mhz   - system clock (rising edge)
//             reset      - asynchronous active-high reset
//             tick_1hz   - one-cycle strobe per second
//             hour/minute/second - current time, packed BCD
//             wr_en/wr_idx/wr_time/wr_arm - slot programming port
//             ack        - stop-ringing pulse
//             snooze     - snooze pulse (optional feature)
//             piezo      - gated tone output (registered)
//             ringing    - high while an alarm is sounding
//             ring_idx   - slot currently (or last) ringing
//             armed      - armed mask, one bit per slot
//  Revision : 1.0 - initial release
// ============================================================================
module multi_alarm #(
    parameter int N_ALARMS    = 4,
    parameter int TONE_HALF   = 500,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                                            clk_1Mhz,
    input  logic                                            reset,
    input  logic                                            tick_1hz,
    input  logic [7:0]                                      hour,
    input  logic [7:0]                                      minute,
    input  logic [7:0]                                      second,
    input  logic                                            wr_en,
    input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] wr_idx,
    input  logic [23:0]                                     wr_time,
    input  logic                                            wr_arm,
    input  logic                                            ack,
    input  logic                                            snooze,
    output logic                                            piezo,
    output logic                                            ringing,
    output logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] ring_idx,
    output logic [N_ALARMS-1:0]                             armed
);

    localparam int c_idx_w  = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int c_tone_w = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int c_ring_w = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

    localparam logic [c_idx_w:0]    c_n_slots   = (c_idx_w+1)'(N_ALARMS);
    localparam logic [c_tone_w-1:0] c_tone_last = c_tone_w'(TONE_HALF - 1);
    localparam logic [c_ring_w-1:0] c_ring_last = c_ring_w'(RING_SECS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RING = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [23:0]           r_time [N_ALARMS];
    logic [N_ALARMS-1:0]   r_armed;
    logic [N_ALARMS-1:0]   r_pending;

    logic [c_idx_w-1:0]    r_ring_idx;
    logic [c_ring_w-1:0]   r_ring_cnt;
    logic [c_tone_w-1:0]   r_tone_cnt;
    logic                  r_tone;
    logic                  r_gate;
    logic                  r_piezo;

    logic [c_idx_w-1:0]    w_ring_idx_nxt;
    logic [c_ring_w-1:0]   w_ring_cnt_nxt;
    logic [c_tone_w-1:0]   w_tone_cnt_nxt;
    logic                  w_tone_nxt;
    logic                  w_gate_nxt;

    logic                  w_wr_valid;
    logic [N_ALARMS-1:0]   w_wr_sel;
    logic [N_ALARMS-1:0]   w_match;
    logic [N_ALARMS-1:0]   w_snz_fire;
    logic [c_idx_w-1:0]    w_pick_idx;
    logic                  w_take;
    logic                  w_disarm_ring;
    logic [23:0]           w_time_now;

    assign w_time_now    = {hour, minute, second};
    assign w_wr_valid    = wr_en && ({1'b0, wr_idx} < c_n_slots);
    // Only a write that clears the armed bit of the sounding slot stops it.
    assign w_disarm_ring = w_wr_valid && (wr_idx == r_ring_idx) && !wr_arm;

    // Per-slot write decode and time match
    always_comb begin
        w_wr_sel = '0;
        w_match  = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_wr_sel[i] = w_wr_valid && (wr_idx == c_idx_w'(i));
            w_match[i]  = tick_1hz && r_armed[i] && (r_time[i] == w_time_now);
        end
    end

    // Lowest pending index wins: scan downward so the last hit is the lowest
    always_comb begin
        w_pick_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_idx = c_idx_w'(i);
            end
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int c_snz_w = $clog2(SNOOZE_SECS + 1);
    localparam logic [c_snz_w-1:0] c_snz_load = c_snz_w'(SNOOZE_SECS);

    logic [c_snz_w-1:0] r_snz_cnt [N_ALARMS];
    logic               w_snz_load;

    // A counter stepping from 1 to 0 re-triggers its slot if still armed
    always_comb begin
        w_snz_fire = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_snz_fire[i] = tick_1hz && r_armed[i] && (r_snz_cnt[i] == c_snz_w'(1));
        end
    end
`else
    logic w_snooze_unused;
    assign w_snooze_unused = snooze;
    assign w_snz_fire      = '0;
`endif

    // ------------------------------------------------------------------
    // FSM next state plus ring datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_take         = 1'b0;
        w_ring_idx_nxt = r_ring_idx;
        w_ring_cnt_nxt = r_ring_cnt;
        w_tone_cnt_nxt = r_tone_cnt;
        w_tone_nxt     = r_tone;
        w_gate_nxt     = r_gate;
`ifdef MULTI_ALARM_SNOOZE_EN
        w_snz_load     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt    = S_RING;
                    w_take         = 1'b1;
                    w_ring_idx_nxt = w_pick_idx;
                    w_ring_cnt_nxt = '0;
                    w_tone_cnt_nxt = '0;
                    w_tone_nxt     = 1'b0;
                    w_gate_nxt     = 1'b1;
                end
            end
            S_RING: begin
                if (tick_1hz) begin
                    w_ring_cnt_nxt = r_ring_cnt + 1'b1;
                    w_gate_nxt     = ~r_gate;
                end
                if (r_tone_cnt == c_tone_last) begin
                    w_tone_cnt_nxt = '0;
                    w_tone_nxt     = ~r_tone;
                end else begin
                    w_tone_cnt_nxt = r_tone_cnt + 1'b1;
                end
                // Stop sources in priority order
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end else if (w_disarm_ring) begin
                    w_state_nxt = S_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                end else if (snooze) begin
                    w_state_nxt = S_IDLE;
                    w_snz_load  = 1'b1;
`endif
                end else if (tick_1hz && (r_ring_cnt == c_ring_last)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and ring datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ring_idx <= '0;
            r_ring_cnt <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_gate     <= 1'b0;
            r_piezo    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ring_idx <= w_ring_idx_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_tone_cnt <= w_tone_cnt_nxt;
            r_tone     <= w_tone_nxt;
            r_gate     <= w_gate_nxt;
            // Registered from next-state values so piezo drops on the same
            // edge that leaves RING.
            r_piezo    <= (w_state_nxt == S_RING) && w_tone_nxt && w_gate_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_time[i]    <= '0;
                r_armed[i]   <= 1'b0;
                r_pending[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (w_wr_sel[i]) begin
                    // A write overrides any match for this slot this cycle
                    r_time[i]    <= wr_time;
                    r_armed[i]   <= wr_arm;
                    r_pending[i] <= 1'b0;
                end else begin
                    r_pending[i] <= (r_pending[i] && !(w_take && (w_pick_idx == c_idx_w'(i))))
                                    || w_match[i] || w_snz_fire[i];
                end
            end
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                r_snz_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (w_wr_sel[i]) begin
                    r_snz_cnt[i] <= '0;
                end else if (w_snz_load && (r_ring_idx == c_idx_w'(i))) begin
                    r_snz_cnt[i] <= c_snz_load;
                end else if (tick_1hz && (r_snz_cnt[i] != '0)) begin
                    r_snz_cnt[i] <= r_snz_cnt[i] - 1'b1;
                end
            end
        end
    end
`endif

    assign piezo    = r_piezo;
    assign ringing  = (r_state == S_RING);
    assign ring_idx = r_ring_idx;
    assign armed    = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multi_alarm
//  Purpose  : Directed self-checking bench for multi_alarm (4 slots,
//             TONE_HALF=5, RING_SECS=3, SNOOZE_SECS=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_alarm;

    logic        clk_1Mhz = 1'b0;
    logic        reset;
    logic        tick_1hz;
    logic [7:0]  hour, minute, second;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [23:0] wr_time;
    logic        wr_arm;
    logic        ack;
    logic        snooze;
    logic        piezo;
    logic        ringing;
    logic [1:0]  ring_idx;
    logic [3:0]  armed;

    int n_total = 0;
    int n_pass  = 0;
    logic seen;

    multi_alarm #(
        .N_ALARMS    (4),
        .TONE_HALF   (5),
        .RING_SECS   (3),
        .SNOOZE_SECS (5)
    ) u_dut (
        .clk_1Mhz (clk_1Mhz),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_time  (wr_time),
        .wr_arm   (wr_arm),
        .ack      (ack),
        .snooze   (snooze),
        .piezo    (piezo),
        .ringing  (ringing),
        .ring_idx (ring_idx),
        .armed    (armed)
    );

    always #5 clk_1Mhz = ~clk_1Mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; leave 1 ns after the edge for driving and sampling
    task automatic cyc();
        @(posedge clk_1Mhz);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input logic [1:0] idx, input logic [23:0] t, input logic arm);
        wr_en = 1'b1; wr_idx = idx; wr_time = t; wr_arm = arm;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic tick_at(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hour = h; minute = m; second = s; tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; hour = 8'h00; minute = 8'h00; second = 8'h00;
        wr_en = 1'b0; wr_idx = 2'd0; wr_time = 24'h0; wr_arm = 1'b0;
        ack = 1'b0; snooze = 1'b0;
        cycles(3);
        chk("rst_ringing",  32'(ringing),  32'd0);
        chk("rst_piezo",    32'(piezo),    32'd0);
        chk("rst_armed",    32'(armed),    32'd0);
        chk("rst_ring_idx", 32'(ring_idx), 32'd0);
        reset = 1'b0;
        cyc();

        // ---------------- basic ring ----------------
        wr(2'd1, 24'h073000, 1'b1);
        chk("arm_slot1", 32'(armed), 32'h2);
        tick_at(8'h07, 8'h30, 8'h00);
        chk("match_edge_idle", 32'(ringing), 32'd0);
        cyc();                                      // RING entry edge E
        chk("ring_enter",     32'(ringing),  32'd1);
        chk("ring_idx_1",     32'(ring_idx), 32'd1);
        chk("piezo_entry",    32'(piezo),    32'd0);
        cycles(4);
        chk("piezo_pre_rise", 32'(piezo),    32'd0);
        cyc();                                      // E+5
        chk("piezo_rise",     32'(piezo),    32'd1);
        cycles(4);
        chk("piezo_high",     32'(piezo),    32'd1);
        cyc();                                      // E+10
        chk("piezo_fall",     32'(piezo),    32'd0);
        tick_at(8'h07, 8'h30, 8'h01);               // gate closes
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (piezo) seen = 1'b1;
            cyc();
        end
        chk("silent_second", 32'(seen),    32'd0);
        chk("still_ringing", 32'(ringing), 32'd1);
        tick_at(8'h07, 8'h30, 8'h02);               // gate reopens
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (piezo) seen = 1'b1;
        end
        chk("tone_resumes", 32'(seen), 32'd1);
        ack_pulse();
        chk("ack_ringing", 32'(ringing), 32'd0);
        chk("ack_piezo",   32'(piezo),   32'd0);

        // ---------------- priority ----------------
        wr(2'd0, 24'h120000, 1'b1);
        wr(2'd2, 24'h120000, 1'b1);
        wr(2'd3, 24'h120000, 1'b0);
        chk("armed_mask", 32'(armed), 32'h7);
        tick_at(8'h12, 8'h00, 8'h00);
        cyc();
        chk("prio_ring",  32'(ringing),  32'd1);
        chk("prio_idx0",  32'(ring_idx), 32'd0);
        ack_pulse();
        chk("idle_gap",   32'(ringing),  32'd0);
        cyc();
        chk("second_ring", 32'(ringing),  32'd1);
        chk("prio_idx2",   32'(ring_idx), 32'd2);
        ack_pulse();
        chk("ack2", 32'(ringing), 32'd0);
        cycles(5);
        chk("slot3_silent",  32'(ringing),  32'd0);
        chk("ring_idx_hold", 32'(ring_idx), 32'd2);

        // ---------------- timeout ----------------
        wr(2'd1, 24'h083000, 1'b1);
        tick_at(8'h08, 8'h30, 8'h00);
        cyc();
        chk("to_ring", 32'(ringing),  32'd1);
        chk("to_idx",  32'(ring_idx), 32'd1);
        cycles(2);
        tick_at(8'h08, 8'h30, 8'h01);
        chk("to_tick1", 32'(ringing), 32'd1);
        cycles(2);
        tick_at(8'h08, 8'h30, 8'h02);
        chk("to_tick2", 32'(ringing), 32'd1);
        cycles(2);
        tick_at(8'h08, 8'h30, 8'h03);
        chk("to_tick3_stop", 32'(ringing), 32'd0);
        chk("to_piezo",      32'(piezo),   32'd0);

        // ---------------- disarm while ringing ----------------
        tick_at(8'h08, 8'h30, 8'h00);
        cyc();
        chk("dis_ring", 32'(ringing), 32'd1);
        wr(2'd1, 24'h083000, 1'b1);
        chk("rearm_keeps", 32'(ringing), 32'd1);
        wr(2'd1, 24'h083000, 1'b0);
        chk("disarm_stop",  32'(ringing), 32'd0);
        chk("disarm_armed", 32'(armed),   32'h5);

        // ---------------- ack + snooze together ----------------
        wr(2'd1, 24'h090000, 1'b1);
        tick_at(8'h09, 8'h00, 8'h00);
        cyc();
        chk("as_ring", 32'(ringing), 32'd1);
        ack = 1'b1; snooze = 1'b1;
        cyc();
        ack = 1'b0; snooze = 1'b0;
        chk("as_stop", 32'(ringing), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cycles(2);
            tick_at(8'h09, 8'h00, 8'(k));
        end
        cycles(2);
        chk("no_snooze_after_ack", 32'(ringing), 32'd0);

        // ---------------- snooze ----------------
        tick_at(8'h09, 8'h00, 8'h00);
        cyc();
        chk("snz_ring", 32'(ringing),  32'd1);
        chk("snz_idx",  32'(ring_idx), 32'd1);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
        chk("snooze_stop", 32'(ringing), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cycles(2);
            tick_at(8'h09, 8'h00, 8'(8'h10 + k));
            chk("snooze_wait", 32'(ringing), 32'd0);
        end
        cycles(2);
        tick_at(8'h09, 8'h00, 8'h15);
        chk("snooze_expire_edge", 32'(ringing), 32'd0);
        cyc();
        chk("snooze_rering", 32'(ringing),  32'd1);
        chk("snooze_idx",    32'(ring_idx), 32'd1);
        ack_pulse();
`else
        chk("snooze_ignored", 32'(ringing), 32'd1);
        ack_pulse();
`endif
        chk("snz_done", 32'(ringing), 32'd0);

        // ---------------- reset mid-ring ----------------
        cycles(2);
        tick_at(8'h09, 8'h00, 8'h00);
        cyc();
        chk("rr_ring", 32'(ringing), 32'd1);
        cycles(5);
        chk("rr_piezo_high", 32'(piezo), 32'd1);
        #1 reset = 1'b1;
        #2;
        chk("rr_async_ringing", 32'(ringing), 32'd0);
        chk("rr_async_piezo",   32'(piezo),   32'd0);
        chk("rr_async_armed",   32'(armed),   32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        tick_at(8'h09, 8'h00, 8'h00);
        cyc();
        chk("rr_no_fire", 32'(ringing), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
